// File: rtl/mul_cascade_pkg.sv
// rtl/mul_cascade_pkg.sv - shared constants, FSM states and column geometry for the cascade multiplier
package mul_cascade_pkg;

  localparam int W    = 24;
  localparam int NCOL = 2 * W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Number of partial-product bits that land in column k.
  function automatic int col_height(input int k, input int w = W);
    return (k + 1 < 2 * w - 1 - k) ? k + 1 : 2 * w - 1 - k;
  endfunction

  // Lowest multiplicand index contributing to column k.
  function automatic int col_base(input int k, input int w = W);
    return (k - w + 1 > 0) ? k - w + 1 : 0;
  endfunction

endpackage

// File: rtl/pp_step_gen.sv
// rtl/pp_step_gen.sv - combinational partial-product column vector for one serial step
module pp_step_gen #(
  parameter int W = mul_cascade_pkg::W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [15:0]    step,
  output logic [2*W-2:0] bits
);
  import mul_cascade_pkg::*;

  // Short columns are front-padded with zeros so every column finishes on the last step.
  always_comb begin
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    int s, h, i0, m;
    bits = '0;
    sa   = '0;
    sb   = '0;
    s    = int'(step);
    for (int k = 0; k < 2 * W - 1; k++) begin
      h  = col_height(k, W);
      i0 = col_base(k, W);
      m  = s - (W - h);
      if (m >= 0) begin
        sa   = a >> (i0 + m);
        sb   = b >> (k - i0 - m);
        bits = bits | ({{(2 * W - 2){1'b0}}, sa[0] & sb[0]} << k);
      end
    end
  end

endmodule

// File: rtl/pp_serial_loader.sv
// rtl/pp_serial_loader.sv - serial partial-product feeder and result collector for the cascade multiplier
module pp_serial_loader #(
  parameter int W           = mul_cascade_pkg::W,
  parameter int CAPTURE_LAT = 0,
  parameter bit CHECK       = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [2*W-2:0] pp_bits,
  input  logic [2*W-1:0] res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           err
);
  import mul_cascade_pkg::*;

  localparam logic [15:0] LAST_STEP = 16'(W - 1);
  localparam logic [15:0] LAST_WAIT = 16'(CAPTURE_LAT + 1);

  state_t         state;
  logic [15:0]    cnt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-2:0] step_bits;
  logic           mismatch;

  pp_step_gen #(.W(W)) u_gen (
    .a    (a_q),
    .b    (b_q),
    .step (cnt),
    .bits (step_bits)
  );

  generate
    if (CHECK) begin : g_check
      logic [2*W-1:0] golden;
      assign golden   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
      assign mismatch = (res != golden);
    end else begin : g_nocheck
      assign mismatch = 1'b0;
    end
  endgenerate

  assign in_ready = (state == IDLE);

  // The shift registers never stall, so res is only coherent on the exact capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pp_bits   <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          pp_bits <= step_bits;
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          pp_bits <= '0;
          if (cnt == LAST_WAIT) begin
            out_prod  <= res;
            err       <= mismatch;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_serial_loader.sv
// tb/tb_pp_serial_loader.sv - scoreboard bench with a shift-register/compressor model behind the loader
module tb_pp_serial_loader;
  import mul_cascade_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic [NCOL-1:0] pp_bits;
  logic [2*W-1:0]  res;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  out_prod;
  logic            err;
  logic            fault = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           e;
    int             acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic ov_prev = 1'b0;
  logic [NCOL-1:0] pp_seen[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pp_serial_loader #(.W(W), .CAPTURE_LAT(0), .CHECK(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .pp_bits   (pp_bits),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .err       (err)
  );

  // Per-column shift registers feeding a popcount compressor.
  logic [W-1:0] sr [NCOL];
  initial for (int k = 0; k < NCOL; k++) sr[k] = '0;
  always @(posedge clk) for (int k = 0; k < NCOL; k++) sr[k] <= {sr[k][W-2:0], pp_bits[k]};

  always_comb begin
    logic [2*W-1:0] acc;
    logic [W-1:0]   col;
    acc = '0;
    col = '0;
    for (int k = 0; k < NCOL; k++) begin
      col = sr[k];
      for (int d = 0; d < W; d++) begin
        if (d < col_height(k)) acc = acc + ({{(2*W-1){1'b0}}, col[0]} << k);
        col = col >> 1;
      end
    end
    res = acc ^ (fault ? 48'h20 : 48'h0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NCOL-1:0] exp_step(input logic [W-1:0] a, input logic [W-1:0] b, input int t);
    logic [NCOL-1:0] v;
    logic [W-1:0] sa, sb;
    v = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if ((W - col_height(i + j)) + (i - col_base(i + j)) == t) begin
          sa = a >> i;
          sb = b >> j;
          v  = v | ({{(NCOL-1){1'b0}}, sa[0] & sb[0]} << (i + j));
        end
    return v;
  endfunction

  function automatic logic [W-1:0] pp_col(input int k);
    logic [W-1:0] v;
    logic [NCOL-1:0] s;
    v = '0;
    for (int t = 0; t < pp_seen.size(); t++) begin
      s = pp_seen[t] >> k;
      v = v | ({{(W-1){1'b0}}, s[0]} << t);
    end
    return v;
  endfunction

  function automatic logic [NCOL-1:0] pp_or_all();
    logic [NCOL-1:0] v;
    v = '0;
    for (int t = 0; t < pp_seen.size(); t++) v = v | pp_seen[t];
    return v;
  endfunction

  // Monitor: pops one expectation each time a new result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got 0x%0h, required no result", out_prod);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_prod", out_prod, mon_e.prod);
          chk("result_err", err, mon_e.e);
          chk("accept_to_valid_cycles", cyc - mon_e.acc, 26);
        end
      end
      ov_prev <= out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] prod,
                      input logic e, input bit push, output int acc);
    int n;
    exp_t x;
    n = 0;
    acc = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc = cyc;
      x.prod = prod;
      x.e = e;
      x.acc = cyc;
      if (push) exp_q.push_back(x);
    end
  endtask

  task automatic check_pp(input logic [W-1:0] a, input logic [W-1:0] b, input int nsteps);
    pp_seen.delete();
    @(negedge clk);
    chk("pp_before_first_step", pp_bits, '0);
    for (int t = 0; t < nsteps; t++) begin
      @(negedge clk);
      pp_seen.push_back(pp_bits);
      chk($sformatf("pp_step%0d", t), pp_bits, exp_step(a, b, t));
    end
    if (nsteps == W) begin
      @(negedge clk);
      chk("pp_zero_after_load", pp_bits, '0);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: out_valid stayed 0, required 1");
    end
  endtask

  task automatic wait_result();
    wait_valid();
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int hcyc;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_pp_bits", pp_bits, '0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_prod", out_prod, '0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;

    send(24'h0, 24'h0, 48'h0, 1'b0, 1'b1, acc);
    check_pp(24'h0, 24'h0, W);
    wait_result();

    send(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b0, 1'b1, acc);
    check_pp(24'hFFFFFF, 24'hFFFFFF, W);
    chk("full_col23_steps", pp_col(23), 24'hFFFFFF);
    chk("full_col0_steps", pp_col(0), 24'h800000);
    wait_result();

    send(24'h000001, 24'h800000, 48'h000000800000, 1'b0, 1'b1, acc);
    check_pp(24'h000001, 24'h800000, W);
    chk("single_col23_steps", pp_col(23), 24'h000001);
    chk("single_any_column", pp_or_all(), 47'h000000800000);
    wait_result();

    // Back-pressure with a stray request during RESP.
    out_ready = 1'b0;
    send(24'h000123, 24'h000456, 48'h00000004EDC2, 1'b0, 1'b1, acc);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_prod", out_prod, 48'h00000004EDC2);
      chk("bp_in_ready", in_ready, 0);
      if (c == 2) begin
        in_a = 24'h5;
        in_b = 24'h5;
        in_valid = 1'b1;
      end
      if (c == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp_err_held", err, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hcyc = cyc;
    send(24'h2, 24'h3, 48'h6, 1'b0, 1'b1, acc);
    chk("accept_after_handshake", acc - hcyc, 1);
    check_pp(24'h2, 24'h3, W);
    wait_result();

    // Reset while step 10 is on pp_bits.
    send(24'hABCDEF, 24'h123456, 48'h0, 1'b0, 1'b0, acc);
    check_pp(24'hABCDEF, 24'h123456, 11);
    rst_n = 1'b0;
    #1;
    chk("abort_pp_bits", pp_bits, '0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send(24'h3, 24'h5, 48'hF, 1'b0, 1'b1, acc);
    check_pp(24'h3, 24'h5, W);
    wait_result();

    // Corrupted compressor bit must be captured and flagged.
    fault = 1'b1;
    send(24'h7, 24'h9, 48'd63 ^ 48'h20, 1'b1, 1'b1, acc);
    check_pp(24'h7, 24'h9, W);
    wait_result();
    fault = 1'b0;

    repeat (40) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
